sata_link_speed_ctrl: RTL and testbench
=======================================

Name: sata_link_speed_ctrl

Overview:
- Link bring-up supervisor placed above the OOB/link-init block.
- Selects the SATA generation, drives the PHY line-rate change handshake, pulses link_reset into the OOB block, and watches for linkup.
- Retries each speed a fixed number of times, then steps the speed down (gen3 → gen2 → gen1). After gen1 fails, it wraps back to the top speed.
- Restarts negotiation if an established link drops or the device sends COMINIT.

Parameters:
- RST_CYCLES, 16: cycles link_reset is held per attempt (≥1).
- LINK_TIMEOUT, 200000: cycles allowed in WAIT_LINK before the attempt fails (24-bit counter).
- ACK_TIMEOUT, 1024: cycles allowed for rate_ack (24-bit counter shared).
- ATTEMPTS_PER_GEN, 3: failed attempts at one gen before stepping down (≥1).
- DROP_FILTER, 8: consecutive cycles oob_linkup must be low while LINKED to declare a drop.

Ports:
- clk  in  1  clock
- reset  in  1  reset (see Behaviour)
- enable  in  1  level; 1 = negotiate/maintain link
- max_gen  in  2  highest allowed gen: 00 gen1, 01 gen2, 10 gen3; 11 is treated as 10
- oob_linkup  in  1  linkup from OOB block
- cominitdet  in  1  device COMINIT detected
- rate_ack  in  1  PHY rate change complete
- gen  out  2  current generation to OOB block and PHY
- rate_req  out  1  rate change request, level
- link_reset  out  1  reset to OOB block
- linkup  out  1  qualified link-up status
- neg_fail  out  1  sticky: all gens exhausted once
- rate_err  out  1  sticky: rate_ack timeout seen
- attempt_cnt  out  2  failed attempts at current gen
- state_out  out  3  FSM encoding for debug

Behaviour:
- Reset and clock: reset is asynchronous, active-high; clock is clk.
- Reset values:
  - state IDLE (000), gen=00, rate_req=0, link_reset=1, linkup=0.
  - neg_fail=0, rate_err=0, attempt_cnt=0, all counters 0.
- All outputs are registered.
- States:
  - IDLE(000): link_reset=1.
    - If enable=1: gen←clamp(max_gen), attempt_cnt←0, go RATE_SET.
  - RATE_SET(001): rate_req=1, link_reset=1, counter increments.
    - rate_ack=1: rate_req drops the next cycle; go RESET_LINK.
    - Counter reaches ACK_TIMEOUT-1 with no ack: set rate_err; go RESET_LINK.
  - RESET_LINK(010): link_reset=1 for exactly RST_CYCLES cycles, then go WAIT_LINK with the counter cleared.
  - WAIT_LINK(011): link_reset=0.
    - oob_linkup=1: go LINKED, linkup=1 next cycle, attempt_cnt←0, neg_fail←0.
    - Counter reaches LINK_TIMEOUT-1: go FAIL_STEP.
    - Linkup is checked before timeout, so if both occur on the same cycle, linkup wins.
  - FAIL_STEP(100): one cycle.
    - If attempt_cnt+1 < ATTEMPTS_PER_GEN: attempt_cnt++, gen unchanged, go RESET_LINK (no rate change).
    - Otherwise: attempt_cnt←0.
      - If gen>00: gen←gen-1.
      - If gen=00: gen←clamp(max_gen) and neg_fail←1.
      - Go RATE_SET.
  - LINKED(101): link_reset=0, linkup=1.
    - A drop counter increments while oob_linkup=0 and clears when oob_linkup=1.
    - Drop counter reaching DROP_FILTER, or cominitdet=1: linkup←0, gen←clamp(max_gen), attempt_cnt←0, go RATE_SET.
- enable=0 in any state: next cycle go IDLE, rate_req=0, link_reset=1, linkup=0. neg_fail and rate_err clear on entering IDLE.
- max_gen is sampled only on IDLE exit, at gen wrap, and at drop restart. Changes at other times are ignored until then.
- cominitdet is ignored outside LINKED.
- rate_ack outside RATE_SET is ignored.
- Counter widths are 24 bits. The counter clears on every state change.

Test Plan:
- enable=1, max_gen=10, rate_ack 3 cycles after rate_req, oob_linkup rises 50 cycles into WAIT_LINK → gen=10, link_reset high for exactly 16 cycles, linkup=1, attempt_cnt=0, neg_fail=0.
- Params LINK_TIMEOUT=100, ATTEMPTS_PER_GEN=3, max_gen=10, oob_linkup never high → 3 attempts at each gen in order 10, 01, 00. Gen then wraps to 10 with neg_fail=1. rate_req is issued only on gen changes.
- Link established, then oob_linkup low for 7 cycles and high again → linkup stays 1. Low for 8 cycles → linkup=0, state RATE_SET, gen=max_gen.
- rate_ack never asserted, ACK_TIMEOUT=1024 → rate_err=1 after 1024 cycles, RESET_LINK entered, retries continue.
- max_gen=11 → gen driven as 10. cominitdet pulse while LINKED → restart via RATE_SET.
- Boundary and reset cases:
  - Assert reset during WAIT_LINK → all outputs return to reset values immediately.
  - Drop enable mid-RESET_LINK → IDLE next cycle, link_reset=1.
  - oob_linkup on the timeout cycle → LINKED.

Source files
------------

// File: rtl/sata_link_speed_ctrl_if.sv
// sata_link_speed_ctrl_if: link supervisor control/status bundle (i_ = into the supervisor, o_ = out of it)
interface sata_link_speed_ctrl_if;
   logic       i_enable;
   logic [1:0] i_max_gen;
   logic       i_oob_linkup;
   logic       i_cominitdet;
   logic       i_rate_ack;
   logic [1:0] o_gen;
   logic       o_rate_req;
   logic       o_link_reset;
   logic       o_linkup;
   logic       o_neg_fail;
   logic       o_rate_err;
   logic [1:0] o_attempt_cnt;
   logic [2:0] o_state_out;
   modport master (
      output i_enable, i_max_gen, i_oob_linkup, i_cominitdet, i_rate_ack,
      input  o_gen, o_rate_req, o_link_reset, o_linkup, o_neg_fail, o_rate_err, o_attempt_cnt, o_state_out
   );
   modport slave (
      input  i_enable, i_max_gen, i_oob_linkup, i_cominitdet, i_rate_ack,
      output o_gen, o_rate_req, o_link_reset, o_linkup, o_neg_fail, o_rate_err, o_attempt_cnt, o_state_out
   );
endinterface

// File: rtl/sata_link_speed_ctrl.sv
// sata_link_speed_ctrl: SATA link bring-up supervisor with per-gen retries, speed step-down and drop restart
module sata_link_speed_ctrl #(
   parameter int RST_CYCLES       = 16,
   parameter int LINK_TIMEOUT     = 200000,
   parameter int ACK_TIMEOUT      = 1024,
   parameter int ATTEMPTS_PER_GEN = 3,
   parameter int DROP_FILTER      = 8
)(
   input logic             clk,
   input logic             reset,
   sata_link_speed_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_RATE_SET = 3'd1, S_RESET_LINK = 3'd2,
      S_WAIT_LINK = 3'd3, S_FAIL_STEP = 3'd4, S_LINKED = 3'd5
   } state_t;
   localparam logic [23:0] L_RST  = 24'(RST_CYCLES - 1);
   localparam logic [23:0] L_LINK = 24'(LINK_TIMEOUT - 1);
   localparam logic [23:0] L_ACK  = 24'(ACK_TIMEOUT - 1);
   localparam logic [23:0] L_DROP = 24'(DROP_FILTER - 1);
   state_t      r_state, w_state_n;
   logic [23:0] r_cnt, w_cnt_n;
   logic [1:0]  r_gen, w_gen_n, r_attempt, w_attempt_n, w_clamp;
   logic        r_neg_fail, w_neg_fail_n, r_rate_err, w_rate_err_n;
   logic        r_rate_req, r_link_reset, r_linkup;
   logic        w_ack_tmo, w_link_tmo, w_rst_done, w_drop, w_retry;
   assign w_clamp    = (bus.i_max_gen == 2'b11) ? 2'b10 : bus.i_max_gen;
   assign w_ack_tmo  = r_cnt == L_ACK;
   assign w_link_tmo = r_cnt == L_LINK;
   assign w_rst_done = r_cnt == L_RST;
   assign w_drop     = !bus.i_oob_linkup && r_cnt == L_DROP;
   assign w_retry    = int'(r_attempt) + 1 < ATTEMPTS_PER_GEN;
   // one counter serves every timed state; in LINKED it only counts consecutive low-linkup cycles
   assign w_cnt_n = (w_state_n != r_state || r_state == S_IDLE || (r_state == S_LINKED && bus.i_oob_linkup))
                    ? '0 : r_cnt + 24'd1;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_gen        <= '0;
         r_attempt    <= '0;
         r_neg_fail   <= 1'b0;
         r_rate_err   <= 1'b0;
         r_rate_req   <= 1'b0;
         r_link_reset <= 1'b1;
         r_linkup     <= 1'b0;
      end else begin
         r_state      <= w_state_n;
         r_cnt        <= w_cnt_n;
         r_gen        <= w_gen_n;
         r_attempt    <= w_attempt_n;
         r_neg_fail   <= w_neg_fail_n;
         r_rate_err   <= w_rate_err_n;
         r_rate_req   <= w_state_n == S_RATE_SET;
         r_link_reset <= !(w_state_n == S_WAIT_LINK || w_state_n == S_LINKED);
         r_linkup     <= w_state_n == S_LINKED;
      end
   end
   always_comb begin
      w_state_n = r_state;
      if (!bus.i_enable) w_state_n = S_IDLE;
      else case (r_state)
         S_IDLE:       w_state_n = S_RATE_SET;
         S_RATE_SET:   w_state_n = (bus.i_rate_ack || w_ack_tmo) ? S_RESET_LINK : S_RATE_SET;
         S_RESET_LINK: w_state_n = w_rst_done ? S_WAIT_LINK : S_RESET_LINK;
         S_WAIT_LINK:  w_state_n = bus.i_oob_linkup ? S_LINKED : w_link_tmo ? S_FAIL_STEP : S_WAIT_LINK;
         S_FAIL_STEP:  w_state_n = w_retry ? S_RESET_LINK : S_RATE_SET;
         S_LINKED:     w_state_n = (w_drop || bus.i_cominitdet) ? S_RATE_SET : S_LINKED;
         default:      w_state_n = S_IDLE;
      endcase
   end
   always_comb begin
      w_gen_n      = r_gen;
      w_attempt_n  = r_attempt;
      w_neg_fail_n = r_neg_fail;
      w_rate_err_n = r_rate_err;
      if (w_state_n == S_IDLE) begin
         w_neg_fail_n = 1'b0;
         w_rate_err_n = 1'b0;
      end else case (r_state)
         S_IDLE: begin
            w_gen_n     = w_clamp;
            w_attempt_n = '0;
         end
         S_RATE_SET: w_rate_err_n = r_rate_err | (!bus.i_rate_ack && w_ack_tmo);
         S_WAIT_LINK: if (bus.i_oob_linkup) begin
            w_attempt_n  = '0;
            w_neg_fail_n = 1'b0;
         end
         S_FAIL_STEP: begin
            w_attempt_n  = w_retry ? r_attempt + 2'd1 : '0;
            w_gen_n      = w_retry ? r_gen : (r_gen == 2'b00) ? w_clamp : r_gen - 2'd1;
            w_neg_fail_n = r_neg_fail | (!w_retry && r_gen == 2'b00);
         end
         S_LINKED: if (w_state_n == S_RATE_SET) begin
            w_gen_n     = w_clamp;
            w_attempt_n = '0;
         end
         default: ;
      endcase
   end
   assign bus.o_gen         = r_gen;
   assign bus.o_rate_req    = r_rate_req;
   assign bus.o_link_reset  = r_link_reset;
   assign bus.o_linkup      = r_linkup;
   assign bus.o_neg_fail    = r_neg_fail;
   assign bus.o_rate_err    = r_rate_err;
   assign bus.o_attempt_cnt = r_attempt;
   assign bus.o_state_out   = r_state;
endmodule

// File: tb/tb_sata_link_speed_ctrl.sv
// tb_sata_link_speed_ctrl: scoreboard of expected {state,gen,attempt} transitions plus point checks
module tb_sata_link_speed_ctrl;
   localparam logic [2:0] IDLE = 3'd0, RSET = 3'd1, RLNK = 3'd2, WAIT = 3'd3, FAIL = 3'd4, LNKD = 3'd5;
   logic clk, reset, auto_ack;
   int   n_cmp, n_err, rq_rise, r0;
   logic [2:0] prev_st;
   logic       prev_rq;
   logic [6:0] sb[$];
   sata_link_speed_ctrl_if dif();
   sata_link_speed_ctrl #(.RST_CYCLES(16), .LINK_TIMEOUT(100), .ACK_TIMEOUT(1024),
                          .ATTEMPTS_PER_GEN(3), .DROP_FILTER(8))
      dut (.clk(clk), .reset(reset), .bus(dif.slave));
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [6:0] e(input logic [2:0] s, input logic [1:0] g, input logic [1:0] a);
      return {s, g, a};
   endfunction
   task automatic wait_st(input string tag, input logic [2:0] s, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (dif.o_state_out == s) break;
      end
      chk(tag, dif.o_state_out, s);
   endtask
   // every state change must match the next queued expectation
   initial begin
      prev_st = 3'd0;
      prev_rq = 1'b0;
      forever begin
         @(negedge clk);
         if (dif.o_state_out !== prev_st) begin
            if (sb.size() == 0) chk("sb_unexpected", {dif.o_state_out, dif.o_gen, dif.o_attempt_cnt}, 32'hff);
            else chk("sb_trans", {dif.o_state_out, dif.o_gen, dif.o_attempt_cnt}, sb.pop_front());
         end
         prev_st = dif.o_state_out;
         if (dif.o_rate_req && !prev_rq) rq_rise++;
         prev_rq = dif.o_rate_req;
      end
   end
   initial forever begin
      @(posedge clk);
      #1;
      if (auto_ack) dif.i_rate_ack = dif.o_rate_req && !dif.i_rate_ack;
   end
   initial begin
      int n;
      n_cmp = 0; n_err = 0; rq_rise = 0; auto_ack = 1'b0;
      reset = 1'b1;
      dif.i_enable = 1'b0; dif.i_max_gen = 2'b10; dif.i_oob_linkup = 1'b0;
      dif.i_cominitdet = 1'b0; dif.i_rate_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", dif.o_state_out, IDLE);
      chk("rst_gen", dif.o_gen, 0);
      chk("rst_rate_req", dif.o_rate_req, 0);
      chk("rst_link_reset", dif.o_link_reset, 1);
      chk("rst_linkup", dif.o_linkup, 0);
      chk("rst_flags", {dif.o_neg_fail, dif.o_rate_err, dif.o_attempt_cnt}, 0);
      reset = 1'b0;
      // first bring-up at gen3 with a 3-cycle rate_ack
      sb.push_back(e(RSET, 2, 0)); sb.push_back(e(RLNK, 2, 0));
      sb.push_back(e(WAIT, 2, 0)); sb.push_back(e(LNKD, 2, 0));
      @(posedge clk); #1 dif.i_enable = 1'b1;
      wait_st("enter_rate_set", RSET, 10);
      chk("rate_req_on", dif.o_rate_req, 1);
      repeat (3) @(posedge clk);
      #1 dif.i_rate_ack = 1'b1;
      @(posedge clk);
      #1 dif.i_rate_ack = 1'b0;
      chk("rate_req_drop", dif.o_rate_req, 0);
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (dif.o_state_out != RLNK) break;
         n++;
         if (!dif.o_link_reset) chk("link_reset_in_rst", dif.o_link_reset, 1);
      end
      chk("reset_link_len", n, 16);
      chk("wait_link_reset_low", dif.o_link_reset, 0);
      repeat (49) @(posedge clk);
      #1 dif.i_oob_linkup = 1'b1;
      wait_st("enter_linked", LNKD, 5);
      chk("linked_status", {dif.o_linkup, dif.o_gen, dif.o_attempt_cnt, dif.o_neg_fail}, {1'b1, 2'b10, 2'b00, 1'b0});
      // 7-cycle glitch is filtered; max_gen change while linked is ignored
      @(posedge clk); #1 dif.i_oob_linkup = 1'b0; dif.i_max_gen = 2'b01;
      repeat (7) @(posedge clk);
      #1 dif.i_oob_linkup = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("glitch7_linkup", dif.o_linkup, 1);
      chk("glitch7_gen", dif.o_gen, 2);
      sb.push_back(e(RSET, 1, 0));
      dif.i_oob_linkup = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("drop8_linkup", dif.o_linkup, 0);
      chk("drop8_state", dif.o_state_out, RSET);
      chk("drop8_gen", dif.o_gen, 1);
      // no rate_ack: timeout sets rate_err and moves on
      sb.push_back(e(RLNK, 1, 0));
      n = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (dif.o_state_out != RSET) break;
         n++;
      end
      chk("ack_tmo_len", n, 1024);
      chk("ack_tmo_rate_err", dif.o_rate_err, 1);
      chk("ack_tmo_state", dif.o_state_out, RLNK);
      sb.push_back(e(IDLE, 1, 0));
      repeat (5) @(posedge clk);
      #1 dif.i_enable = 1'b0;
      @(posedge clk);
      #1;
      chk("disable_state", dif.o_state_out, IDLE);
      chk("disable_outs", {dif.o_link_reset, dif.o_rate_req, dif.o_linkup, dif.o_rate_err}, 4'b1000);
      // exhaust all gens: 3 tries each at 10, 01, 00, then wrap to 10
      repeat (3) @(posedge clk);
      #1 auto_ack = 1'b1; dif.i_max_gen = 2'b10;
      for (int g = 2; g >= 0; g--) begin
         sb.push_back(e(RSET, 2'(g), 0));
         for (int a = 0; a < 3; a++) begin
            sb.push_back(e(RLNK, 2'(g), 2'(a)));
            sb.push_back(e(WAIT, 2'(g), 2'(a)));
            sb.push_back(e(FAIL, 2'(g), 2'(a)));
         end
      end
      sb.push_back(e(RSET, 2, 0));
      r0 = rq_rise;
      dif.i_enable = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (dif.o_neg_fail) break;
      end
      chk("wrap_neg_fail", dif.o_neg_fail, 1);
      chk("wrap_gen", dif.o_gen, 2);
      chk("wrap_rate_req_count", rq_rise - r0, 4);
      chk("wrap_rate_err", dif.o_rate_err, 0);
      // linkup on the exact timeout cycle wins
      sb.push_back(e(RLNK, 2, 0)); sb.push_back(e(WAIT, 2, 0)); sb.push_back(e(LNKD, 2, 0));
      wait_st("tmo_enter_wait", WAIT, 60);
      repeat (99) @(posedge clk);
      #1 dif.i_oob_linkup = 1'b1;
      wait_st("tmo_linked", LNKD, 3);
      chk("tmo_linked_status", {dif.o_linkup, dif.o_neg_fail, dif.o_attempt_cnt}, {1'b1, 1'b0, 2'b00});
      // COMINIT restart with max_gen=11 clamped to gen3; COMINIT ignored in WAIT_LINK
      sb.push_back(e(RSET, 2, 0)); sb.push_back(e(RLNK, 2, 0)); sb.push_back(e(WAIT, 2, 0));
      @(posedge clk);
      #1 dif.i_max_gen = 2'b11; dif.i_cominitdet = 1'b1; dif.i_oob_linkup = 1'b0;
      @(posedge clk);
      #1 dif.i_cominitdet = 1'b0;
      chk("cominit_state", dif.o_state_out, RSET);
      chk("cominit_gen", dif.o_gen, 2);
      wait_st("cominit_wait", WAIT, 40);
      @(posedge clk); #1 dif.i_cominitdet = 1'b1;
      repeat (2) @(posedge clk);
      #1 dif.i_cominitdet = 1'b0;
      chk("cominit_ignored", dif.o_state_out, WAIT);
      // asynchronous reset mid WAIT_LINK
      sb.push_back(e(IDLE, 0, 0));
      @(posedge clk);
      #1 reset = 1'b1; auto_ack = 1'b0; dif.i_enable = 1'b0;
      #1;
      chk("areset_state", dif.o_state_out, IDLE);
      chk("areset_outs", {dif.o_gen, dif.o_rate_req, dif.o_link_reset, dif.o_linkup, dif.o_attempt_cnt}, 7'b00_0_1_0_00);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      chk("sb_leftover", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
